miriscv_data_mem_responder: RTL
===============================

MIRISCV_DATA_MEM_RESPONDER -- requirements
Module: miriscv_data_mem_responder

Interface
REQ-001 Parameter XLEN, default 32, data/address width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 1024, memory size in XLEN-bit words; power of two.
REQ-003 Parameter LATENCY, default 1, request-to-response cycles; legal range 1..4.
REQ-004 Parameter RSP_QUEUE_DEPTH, default 4, response queue entries; power of two, at least 2.
REQ-005 clk_i  input  1  single clock; all logic on rising edge.
REQ-006 rst_i  input  1  synchronous, active-high reset.
REQ-007 data_req_i  input  1  request strobe from core, one request per high cycle; no grant exists, so every request is accepted.
REQ-008 data_we_i  input  1  1 = write, 0 = read; sampled with data_req_i.
REQ-009 data_be_i  input  XLEN/8  byte enables for writes; ignored on reads.
REQ-010 data_addr_i  input  XLEN  byte address; bits [1:0] ignored.
REQ-011 data_wdata_i  input  XLEN  write data, byte lanes aligned to data_be_i.
REQ-012 stall_i  input  1  response back-pressure; while high, no response is presented.
REQ-013 data_rvalid_o  output  1  response strobe, one cycle per accepted request.
REQ-014 data_rdata_o  output  XLEN  read data, valid with data_rvalid_o.
REQ-015 bus_err_o  output  1  sticky out-of-range access flag.
REQ-016 overflow_o  output  1  sticky response-queue overflow flag.

Function
REQ-017 The word index is data_addr_i[log2(DEPTH_WORDS)+1:2]; the access is out of range when data_addr_i >= DEPTH_WORDS*4.
REQ-018 An in-range write updates only the enabled byte lanes at the rising edge that samples the request.
REQ-019 A read samples array contents at acceptance, so a write accepted in cycle N is visible to a read accepted in cycle N+1.
REQ-020 An out-of-range write is discarded, an out-of-range read returns 0, and either one sets bus_err_o.
REQ-021 Every accepted request, read or write, produces exactly one response; a write response carries data_rdata_o = 0.
REQ-022 Responses are returned strictly in acceptance order.
REQ-023 With stall_i low and the queue empty, the response for a request sampled in cycle N appears in cycle N+LATENCY.
REQ-024 Back-to-back requests on consecutive cycles produce back-to-back responses at full throughput.
REQ-025 The delay pipeline always advances and is never stalled; a response leaving it enters the response queue.
REQ-026 The queue head is presented in the cycle after stall_i is low, and one entry is popped per presented cycle.
REQ-027 When stall_i is low and the queue is empty, a response leaving the pipeline may bypass the queue to meet REQ-023.
REQ-028 A simultaneous push and pop on a full queue is legal and does not overflow.
REQ-029 A push to a full queue with no pop drops the incoming response and sets overflow_o.
REQ-030 When data_rvalid_o is low, data_rdata_o is 0.
REQ-031 bus_err_o and overflow_o stay set until reset.

Reset
REQ-032 While rst_i is high: data_rvalid_o = 0, data_rdata_o = 0, bus_err_o = 0, overflow_o = 0; the delay pipeline and queue are emptied; data_req_i is ignored.
REQ-033 Memory array contents are not reset; writes completed before reset persist.
REQ-034 Reset asserted mid-operation discards all in-flight and queued responses; no response is presented for them after reset.
REQ-035 The first request is accepted in the first cycle with rst_i low.

Verification
REQ-036 LATENCY=1: write 0x12345678 (be=1111) to address 0x10, then read 0x10 next cycle -> two rvalid pulses in consecutive cycles; second rdata = 0x12345678.
REQ-037 Partial write be=0010, wdata=0x0000AB00 to 0x10 over 0x12345678, then read -> 0x1234AB78.
REQ-038 LATENCY=3: four back-to-back reads of 0x0, 0x4, 0x8, 0xC -> rvalid high 3..6 cycles after the first request, data in order.
REQ-039 stall_i high for 6 cycles while 4 reads issue, then low -> 4 consecutive ordered responses, overflow_o = 0; repeat with 5 reads -> 4 responses, overflow_o = 1.
REQ-040 Read at address DEPTH_WORDS*4 -> rdata = 0 with rvalid, bus_err_o = 1 and stays 1; memory unchanged.
REQ-041 Assert rst_i for 1 cycle with 2 responses queued -> no rvalid afterwards, flags cleared; a later read returns pre-reset written data.

Source files
------------

// File: rtl/miriscv_data_mem_responder_if.sv
// Core-side data bus of the miriscv data memory responder.
// The core drives requests and back-pressure; the responder returns responses and flags.
interface miriscv_data_mem_responder_if #(
    parameter int XLEN = 32
);
    logic              data_req_i;
    logic              data_we_i;
    logic [XLEN/8-1:0] data_be_i;
    logic [XLEN-1:0]   data_addr_i;
    logic [XLEN-1:0]   data_wdata_i;
    logic              stall_i;
    logic              data_rvalid_o;
    logic [XLEN-1:0]   data_rdata_o;
    logic              bus_err_o;
    logic              overflow_o;

    modport master (
        output data_req_i,
        output data_we_i,
        output data_be_i,
        output data_addr_i,
        output data_wdata_i,
        output stall_i,
        input  data_rvalid_o,
        input  data_rdata_o,
        input  bus_err_o,
        input  overflow_o
    );

    modport slave (
        input  data_req_i,
        input  data_we_i,
        input  data_be_i,
        input  data_addr_i,
        input  data_wdata_i,
        input  stall_i,
        output data_rvalid_o,
        output data_rdata_o,
        output bus_err_o,
        output overflow_o
    );
endinterface

// File: rtl/miriscv_data_mem_responder.sv
// Data memory model for the miriscv core: word array with byte-enable writes,
// fixed-latency response pipeline feeding an in-order response queue.
module miriscv_data_mem_responder #(
    parameter int XLEN            = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 1,
    parameter int RSP_QUEUE_DEPTH = 4
) (
    input logic                          clk_i,
    input logic                          rst_i,
    miriscv_data_mem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int QW = $clog2(RSP_QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) * 64'd4;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            acc;
    logic            oob;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] acc_data;

    logic            leave_valid;
    logic [XLEN-1:0] leave_data;

    logic [XLEN-1:0] q_data [RSP_QUEUE_DEPTH];
    logic [QW-1:0]   head;
    logic [QW-1:0]   tail;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            do_push;
    logic            drop;

    logic            rvalid_q;
    logic [XLEN-1:0] rdata_q;
    logic            bus_err_q;
    logic            overflow_q;

    // Requests are ignored during reset; otherwise every strobe is accepted.
    assign acc = bus.data_req_i && !rst_i;
    assign oob = 64'(bus.data_addr_i) >= LIMIT;
    assign idx = bus.data_addr_i[AW+1:2];

    // Reads see the array before this edge's write; writes and misses answer 0.
    assign acc_data = (bus.data_we_i || oob) ? '0 : mem[idx];

    // Byte-lane write of in-range stores; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (acc && bus.data_we_i && !oob) begin
            for (int b = 0; b < XLEN/8; b++) begin
                if (bus.data_be_i[b]) begin
                    mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // The output register itself is the last latency stage, so only
    // LATENCY-1 extra stages are needed in front of it.
    generate
        if (LATENCY == 1) begin : g_nopipe
            assign leave_valid = acc;
            assign leave_data  = acc_data;
        end else begin : g_pipe
            logic [LATENCY-2:0] pv;
            logic [XLEN-1:0]    pd [LATENCY-1];

            // Free-running delay line; never stalled.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    pv <= '0;
                end else begin
                    pv[0] <= acc;
                    for (int k = 1; k < LATENCY-1; k++) begin
                        pv[k] <= pv[k-1];
                    end
                end
                pd[0] <= acc_data;
                for (int k = 1; k < LATENCY-1; k++) begin
                    pd[k] <= pd[k-1];
                end
            end

            assign leave_valid = pv[LATENCY-2];
            assign leave_data  = pd[LATENCY-2];
        end
    endgenerate

    assign empty   = (count == '0);
    assign full    = (count == CW'(RSP_QUEUE_DEPTH));
    assign pop     = !bus.stall_i && !empty;
    assign bypass  = !bus.stall_i && empty && leave_valid;
    assign push    = leave_valid && !bypass;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // Queue storage; pointers and occupancy live in the control block.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            q_data[tail] <= leave_data;
        end
    end

    // Queue control, registered response and sticky error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            bus_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count    <= count + CW'(do_push) - CW'(pop);
            rvalid_q <= pop || bypass;
            if (pop) begin
                rdata_q <= q_data[head];
            end else if (bypass) begin
                rdata_q <= leave_data;
            end else begin
                rdata_q <= '0;
            end
            if (acc && oob) begin
                bus_err_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.data_rvalid_o = rvalid_q;
    assign bus.data_rdata_o  = rdata_q;
    assign bus.bus_err_o     = bus_err_q;
    assign bus.overflow_o    = overflow_q;
endmodule
